// File: rtl/spi_peripheral.sv
// SPI target byte shifter (mode 0, MSB first), oversampled in the clk domain.
// Received bytes come out as rx_data/rx_stb. Response bytes go into a
// one-deep pending buffer through tx_data/tx_stb and are shifted out on the
// next SPI byte.
module spi_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_csn,
  input  logic       spi_sdi,
  output logic       spi_sdo,
  output logic       spi_sdo_oe,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  input  logic [7:0] tx_data,
  input  logic       tx_stb,
  output logic       tx_underrun
);

  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, sdi_sync;
  logic                   sck_q, csn_q;
  logic [SYNC_STAGES:0]   settle;
  logic                   armed;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift, tx_shift, tx_buf;
  logic                   buf_vld;

  logic sck_s, csn_s, sdi_s, active;
  logic csn_fall, csn_rise, sck_rise, sck_fall;
  logic byte_load, tx_take;
  logic [7:0] load_byte;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign csn_s = csn_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  // The CSN chain resets high, so a pin held low across reset would look like
  // a falling edge. Transfers are only armed once the chain has refilled from
  // the pin and CSN has been seen high.
  assign active   = armed & ~csn_s;
  assign csn_fall = armed & csn_q & ~csn_s;
  assign csn_rise = csn_s & ~csn_q;
  assign sck_rise = active & sck_s & ~sck_q;
  assign sck_fall = active & ~sck_s & sck_q;

  // A byte starts at CSN fall or at an SCK fall on the byte boundary.
  assign byte_load = csn_fall | (sck_fall & (bit_cnt == 3'd0));
  assign tx_take   = tx_stb & active;
  // A strobe coinciding with a load bypasses the buffer.
  assign load_byte = tx_take ? tx_data : (buf_vld ? tx_buf : IDLE_BYTE);

  assign spi_sdo = spi_sdo_oe & tx_shift[7];

  // Pin synchronisers plus the edge-detect registers on SCK and CSN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync <= '0;
      csn_sync <= '1;
      sdi_sync <= '0;
      sck_q    <= 1'b0;
      csn_q    <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      sck_q    <= sck_s;
      csn_q    <= csn_s;
    end
  end

  // Arm after the CSN chain holds pin-derived values and CSN is idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      armed  <= armed | (settle[SYNC_STAGES] & csn_s);
    end
  end

  // Receive path: bit counter, RX shifter, completed-byte register and strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_stb   <= 1'b0;
    end else begin
      rx_stb <= 1'b0;
      if (csn_rise) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
      end else if (csn_fall) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        rx_shift <= {rx_shift[6:0], sdi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data <= {rx_shift[6:0], sdi_s};
          rx_stb  <= 1'b1;
        end
      end
    end
  end

  // Transmit path: TX shifter, output enable and underrun strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= 8'h00;
      spi_sdo_oe  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (csn_rise) begin
        tx_shift   <= 8'h00;
        spi_sdo_oe <= 1'b0;
      end else if (byte_load) begin
        tx_shift    <= load_byte;
        tx_underrun <= ~tx_take & ~buf_vld;
        if (csn_fall) spi_sdo_oe <= 1'b1;
      end else if (sck_fall) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  // One-deep pending response buffer; latest strobe wins, a load empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf  <= 8'h00;
      buf_vld <= 1'b0;
    end else if (csn_rise || byte_load) begin
      buf_vld <= 1'b0;
    end else if (tx_take) begin
      tx_buf  <= tx_data;
      buf_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: directed SPI traffic pushes expected
// RX and MISO bytes into queues; monitors pop and compare as bytes appear.
module tb_spi_peripheral;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0, spi_csn = 1'b1, spi_sdi = 1'b0;
  logic       spi_sdo, spi_sdo_oe, rx_stb, tx_underrun;
  logic [7:0] rx_data;
  logic       tx_stb;
  logic [7:0] tx_data;
  logic       tx_stb_m = 1'b0, tx_stb_e = 1'b0;
  logic [7:0] tx_data_m = 8'h00, tx_data_e = 8'h00;

  assign tx_stb  = tx_stb_m | tx_stb_e;
  assign tx_data = tx_stb_e ? tx_data_e : tx_data_m;

  spi_peripheral #(.SYNC_STAGES(SYNC_STAGES), .IDLE_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .rx_data(rx_data), .rx_stb(rx_stb),
    .tx_data(tx_data), .tx_stb(tx_stb), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int und_cnt = 0, und_base = 0;
  bit echo_en = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RX monitor: every rx_stb pops one expected byte; also counts underruns.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_underrun) und_cnt++;
    if (rst_n && rx_stb) begin
      if (exp_rx.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rx_stb_unexpected: got strobe with rx_data %0h, required none", rx_data);
      end else begin
        chk("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
      end
    end
  end

  // MISO monitor: controller samples at SCK rise; 8 bits pop one expected byte.
  initial begin
    automatic int mcnt = 0;
    automatic logic [7:0] mbyte = 8'h00;
    forever begin
      @(posedge spi_sck or posedge spi_csn);
      if (spi_csn) begin
        mcnt = 0;
      end else begin
        chk("sdo_oe_during_bit", {31'h0, spi_sdo_oe}, 32'h1);
        mbyte = {mbyte[6:0], spi_sdo};
        mcnt++;
        if (mcnt == 8) begin
          mcnt = 0;
          if (exp_miso.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL miso_unexpected: got byte %0h, required none", mbyte);
          end else begin
            chk("miso", {24'h0, mbyte}, {24'h0, exp_miso.pop_front()});
          end
        end
      end
    end
  end

  // Downstream echo: answer each received byte with byte+1 one cycle later.
  initial begin
    automatic logic [7:0] v;
    forever begin
      @(negedge clk);
      if (echo_en && rx_stb) begin
        v = rx_data + 8'h01;
        @(posedge clk);
        #1;
        tx_data_e = v;
        tx_stb_e  = 1'b1;
        @(posedge clk);
        #1;
        tx_stb_e = 1'b0;
      end
    end
  end

  // CSN low; optionally pulse tx_stb in the exact cycle the CSN-fall load acts.
  task automatic csn_low(input bit byp, input logic [7:0] bv);
    spi_csn = 1'b0;
    if (byp) begin
      repeat (SYNC_STAGES) tick();
      tx_data_m = bv;
      tx_stb_m  = 1'b1;
      tick();
      tx_stb_m = 1'b0;
      repeat (2) tick();
    end else begin
      repeat (4) tick();
    end
  endtask

  task automatic csn_high();
    spi_csn = 1'b1;
    repeat (6) tick();
  endtask

  task automatic pulse_tx(input logic [7:0] v);
    tx_data_m = v;
    tx_stb_m  = 1'b1;
    tick();
    tx_stb_m = 1'b0;
    tick();
  endtask

  // Full byte at SCK = clk/8. und_exp >= 0 checks underruns since und_base,
  // sampled after the 8th rise is processed and before the boundary fall.
  // byp pulses tx_stb exactly on the boundary load after this byte.
  task automatic xfer(input logic [7:0] d, input logic [7:0] m, input bit byp,
                      input logic [7:0] bv, input int und_exp);
    exp_rx.push_back(d);
    exp_miso.push_back(m);
    for (int i = 7; i >= 0; i--) begin
      spi_sdi = d[i];
      repeat (2) tick();
      spi_sck = 1'b1;
      repeat (4) tick();
      if (i == 0 && und_exp >= 0)
        chk("underrun_count", und_cnt - und_base, und_exp);
      spi_sck = 1'b0;
      if (i == 0 && byp) begin
        repeat (SYNC_STAGES) tick();
        tx_data_m = bv;
        tx_stb_m  = 1'b1;
        tick();
        tx_stb_m = 1'b0;
      end else begin
        repeat (2) tick();
      end
    end
  endtask

  // Partial byte: first n bits MSB first, no expectations pushed.
  task automatic bits(input logic [7:0] d, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_sdi = d[i];
      repeat (2) tick();
      spi_sck = 1'b1;
      repeat (4) tick();
      spi_sck = 1'b0;
      repeat (2) tick();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sdo"},    {31'h0, spi_sdo},     32'h0);
    chk({tag, "_oe"},     {31'h0, spi_sdo_oe},  32'h0);
    chk({tag, "_rx_stb"}, {31'h0, rx_stb},      32'h0);
    chk({tag, "_und"},    {31'h0, tx_underrun}, 32'h0);
    chk({tag, "_rxdata"}, {24'h0, rx_data},     32'h0);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    summary();
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (SYNC_STAGES + 4) tick();
    chk_reset_outputs("after_reset");

    // Single receive with idle response and one underrun
    und_base = und_cnt;
    csn_low(1'b0, 8'h00);
    xfer(8'hA5, 8'h00, 1'b0, 8'h00, 1);
    csn_high();
    chk("single_rx_data_hold", {24'h0, rx_data}, 32'hA5);

    // Echo loop
    echo_en = 1'b1;
    csn_low(1'b0, 8'h00);
    xfer(8'h10, 8'h00, 1'b0, 8'h00, -1);
    xfer(8'h20, 8'h11, 1'b0, 8'h00, -1);
    xfer(8'h30, 8'h21, 1'b0, 8'h00, -1);
    csn_high();
    echo_en = 1'b0;

    // Response strobed into the CSN-fall load: no underrun, oe held high
    und_base = und_cnt;
    csn_low(1'b1, 8'hC3);
    xfer(8'h81, 8'hC3, 1'b0, 8'h00, 0);
    csn_high();

    // Overwrite (latest wins), then bypass on an SCK boundary load
    csn_low(1'b0, 8'h00);
    pulse_tx(8'h11);
    pulse_tx(8'h22);
    xfer(8'h01, 8'h00, 1'b0, 8'h00, -1);
    xfer(8'h02, 8'h22, 1'b1, 8'h5A, -1);
    und_base = und_cnt;
    xfer(8'h03, 8'h5A, 1'b0, 8'h00, 0);
    xfer(8'h04, 8'h00, 1'b0, 8'h00, 1);
    csn_high();

    // Abort mid-byte
    csn_low(1'b0, 8'h00);
    bits(8'hE7, 5);
    csn_high();
    chk("abort_oe", {31'h0, spi_sdo_oe}, 32'h0);
    chk("abort_sdo", {31'h0, spi_sdo}, 32'h0);
    chk("abort_rx_data_kept", {24'h0, rx_data}, 32'h04);
    csn_low(1'b0, 8'h00);
    xfer(8'hFF, 8'h00, 1'b0, 8'h00, -1);
    csn_high();
    chk("after_abort_rx_data", {24'h0, rx_data}, 32'hFF);

    // Reset mid-transfer
    csn_low(1'b0, 8'h00);
    bits(8'h96, 3);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    spi_csn = 1'b1;
    spi_sck = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    csn_low(1'b0, 8'h00);
    xfer(8'h3C, 8'h00, 1'b0, 8'h00, -1);
    csn_high();
    chk("after_reset_rx_data", {24'h0, rx_data}, 32'h3C);

    repeat (10) tick();
    chk("rx_queue_drained", exp_rx.size(), 32'h0);
    chk("miso_queue_drained", exp_miso.size(), 32'h0);
    summary();
    $finish;
  end

endmodule
